lfsr_gen: RTL and testbench

Parametrised Fibonacci LFSR for pseudo-random bit generation and scrambling. Width, tap polynomial and seed are configurable.
Supports serial and parallel loading, all-zero lock-up detection with optional auto-reseed, and a period marker with a step counter for self-checking.
Used as a pattern source and test-data generator alongside the adder datapaths.

---
 rtl/lfsr_gen.sv | 94 +++++++++
 tb/tb_lfsr_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR pattern source with serial/parallel load, lock-up detection and period marker.
// All outputs are registered; state and data_out reflect a qualifying edge one clock later.
module lfsr_gen #(
   parameter int              WIDTH       = 15,
   parameter logic [WIDTH-1:0] TAPS        = 15'h6000,
   parameter logic [WIDTH-1:0] SEED        = 15'h0001,
   parameter bit              AUTO_RESEED = 1'b1
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic             enable,
   input  logic             load,
   input  logic             data_in,
   input  logic             par_load,
   input  logic [WIDTH-1:0] par_data,
   output logic             data_out,
   output logic [WIDTH-1:0] state,
   output logic             lockup,
   output logic             period_pulse,
   output logic [WIDTH-1:0] step_count
);

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dout_q, dout_d;
   logic             lockup_q, lockup_d;
   logic             pulse_q, pulse_d;
   logic             fb;
   logic [WIDTH-1:0] run_next;

   assign fb       = ^(state_q & TAPS);
   assign run_next = {state_q[WIDTH-2:0], fb};

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      dout_d   = dout_q;
      // With auto-reseed the flag only marks the reseed cycle; otherwise it latches until a load.
      lockup_d = AUTO_RESEED ? 1'b0 : lockup_q;
      pulse_d  = 1'b0;
      if (par_load) begin
         state_d  = par_data;
         count_d  = '0;
         lockup_d = 1'b0;
      end else if (enable && load) begin
         state_d  = {state_q[WIDTH-2:0], data_in};
         dout_d   = state_q[WIDTH-1];
         count_d  = '0;
         lockup_d = 1'b0;
      end else if (enable) begin
         if (state_q == '0) begin
            lockup_d = 1'b1;
            dout_d   = 1'b0;
            if (AUTO_RESEED) begin
               state_d = SEED;
               count_d = '0;
            end
         end else begin
            state_d  = run_next;
            dout_d   = state_q[0];
            lockup_d = 1'b0;
            if (run_next == SEED) begin
               pulse_d = 1'b1;
               count_d = '0;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q  <= SEED;
         count_q  <= '0;
         dout_q   <= 1'b0;
         lockup_q <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         lockup_q <= lockup_d;
         pulse_q  <= pulse_d;
      end
   end

   assign state        = state_q;
   assign step_count   = count_q;
   assign data_out     = dout_q;
   assign lockup       = lockup_q;
   assign period_pulse = pulse_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: two 4-bit instances (auto-reseed on/off) sharing stimulus, plus the default 15-bit build.
// Expected values come from a parity-based behavioural model and from hand-derived constant tables.
module tb_lfsr_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, ld, din, pl;
   logic [3:0] pd;
   logic       a_dout, a_lk, a_pp, b_dout, b_lk, b_pp;
   logic [3:0] a_st, a_sc, b_st, b_sc;

   logic        c_rst, c_en, c_ld, c_din, c_pl;
   logic [14:0] c_pd;
   logic        c_dout, c_lk, c_pp;
   logic [14:0] c_st, c_sc;

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .AUTO_RESEED(1'b1)) u_a (
      .clk(clk), .sync_reset(rst), .enable(en), .load(ld), .data_in(din),
      .par_load(pl), .par_data(pd), .data_out(a_dout), .state(a_st),
      .lockup(a_lk), .period_pulse(a_pp), .step_count(a_sc));

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .AUTO_RESEED(1'b0)) u_b (
      .clk(clk), .sync_reset(rst), .enable(en), .load(ld), .data_in(din),
      .par_load(pl), .par_data(pd), .data_out(b_dout), .state(b_st),
      .lockup(b_lk), .period_pulse(b_pp), .step_count(b_sc));

   lfsr_gen u_c (
      .clk(clk), .sync_reset(c_rst), .enable(c_en), .load(c_ld), .data_in(c_din),
      .par_load(c_pl), .par_data(c_pd), .data_out(c_dout), .state(c_st),
      .lockup(c_lk), .period_pulse(c_pp), .step_count(c_sc));

   typedef struct {
      int st;
      int dout;
      int lk;
      int pp;
      int sc;
   } mdl_t;

   mdl_t ma, mb, mc;
   int   n_cmp = 0;
   int   n_err = 0;
   int   seq[15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
   int   ser_bits[4] = '{1, 0, 1, 1};
   int   ser_dout[4] = '{0, 0, 0, 1};

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock of the reference behaviour, written from the rules: parity of tapped bits, shift-left.
   function automatic mdl_t mstep(input mdl_t m, input int w, input int taps, input int seed,
                                  input int auto_rs, input bit r, input bit e, input bit l,
                                  input bit di, input bit p, input int pdv);
      mdl_t n;
      int   mask;
      int   nx;
      n    = m;
      mask = (1 << w) - 1;
      n.pp = 0;
      if (r) begin
         n.st = seed; n.dout = 0; n.lk = 0; n.sc = 0;
      end else if (p) begin
         n.st = pdv & mask; n.sc = 0; n.lk = 0;
      end else if (e && l) begin
         n.dout = (m.st >> (w - 1)) & 1;
         n.st   = ((m.st << 1) | int'(di)) & mask;
         n.sc   = 0; n.lk = 0;
      end else if (e) begin
         if (m.st == 0) begin
            n.lk = 1; n.dout = 0;
            if (auto_rs != 0) begin
               n.st = seed; n.sc = 0;
            end
         end else begin
            nx     = ((m.st << 1) | ($countones(m.st & taps) % 2)) & mask;
            n.st   = nx;
            n.dout = m.st & 1;
            n.lk   = 0;
            n.sc   = (m.sc + 1) & mask;
            if (nx == seed) begin
               n.pp = 1; n.sc = 0;
            end
         end
      end else if (auto_rs != 0) begin
         n.lk = 0;
      end
      return n;
   endfunction

   task automatic cyc_ab(input bit r, input bit e, input bit l, input bit di, input bit p,
                         input int pdv, input string tag);
      rst = r; en = e; ld = l; din = di; pl = p; pd = 4'(pdv);
      @(posedge clk);
      #1;
      ma = mstep(ma, 4, 12, 1, 1, r, e, l, di, p, pdv);
      mb = mstep(mb, 4, 12, 1, 0, r, e, l, di, p, pdv);
      chk({tag, " a.state"}, int'(a_st), ma.st);
      chk({tag, " a.dout"}, int'(a_dout), ma.dout);
      chk({tag, " a.lockup"}, int'(a_lk), ma.lk);
      chk({tag, " a.pulse"}, int'(a_pp), ma.pp);
      chk({tag, " a.count"}, int'(a_sc), ma.sc);
      chk({tag, " b.state"}, int'(b_st), mb.st);
      chk({tag, " b.dout"}, int'(b_dout), mb.dout);
      chk({tag, " b.lockup"}, int'(b_lk), mb.lk);
      chk({tag, " b.pulse"}, int'(b_pp), mb.pp);
      chk({tag, " b.count"}, int'(b_sc), mb.sc);
   endtask

   task automatic cyc_c(input bit r, input bit e, input bit l, input bit di, input bit p,
                        input int pdv, input string tag);
      c_rst = r; c_en = e; c_ld = l; c_din = di; c_pl = p; c_pd = 15'(pdv);
      @(posedge clk);
      #1;
      mc = mstep(mc, 15, 'h6000, 1, 1, r, e, l, di, p, pdv);
      chk({tag, " c.state"}, int'(c_st), mc.st);
      chk({tag, " c.dout"}, int'(c_dout), mc.dout);
      chk({tag, " c.lockup"}, int'(c_lk), mc.lk);
      chk({tag, " c.pulse"}, int'(c_pp), mc.pp);
      chk({tag, " c.count"}, int'(c_sc), mc.sc);
   endtask

   initial begin
      int npulse;
      int pulse_at;
      int nseed;
      bit r, e, l, di, p;
      int pdv;

      ma = '{0, 0, 0, 0, 0};
      mb = ma;
      mc = ma;
      rst = 1'b1; en = 1'b0; ld = 1'b0; din = 1'b0; pl = 1'b0; pd = 4'd0;
      c_rst = 1'b1; c_en = 1'b0; c_ld = 1'b0; c_din = 1'b0; c_pl = 1'b0; c_pd = 15'd0;

      // Reset state
      cyc_ab(1, 0, 0, 0, 0, 0, "reset");
      chk("reset a.state const", int'(a_st), 1);
      chk("reset a.count const", int'(a_sc), 0);

      // Full period of the 4-bit polynomial
      for (int i = 0; i < 15; i++) begin
         cyc_ab(0, 1, 0, 0, 0, 0, $sformatf("seq%0d", i));
         chk($sformatf("seq%0d state const", i), int'(a_st), seq[i]);
         chk($sformatf("seq%0d pulse const", i), int'(a_pp), (i == 14) ? 1 : 0);
         chk($sformatf("seq%0d count const", i), int'(a_sc), (i == 14) ? 0 : i + 1);
         chk($sformatf("seq%0d dout lag", i), int'(a_dout), (i == 0) ? 1 : (seq[i-1] & 1));
      end

      // Serial shift-in from the seed
      cyc_ab(1, 0, 0, 0, 0, 0, "ser_rst");
      for (int i = 0; i < 4; i++) begin
         cyc_ab(0, 1, 1, ser_bits[i][0], 0, 0, $sformatf("ser%0d", i));
         chk($sformatf("ser%0d dout const", i), int'(a_dout), ser_dout[i]);
      end
      chk("ser final state", int'(a_st), 11);
      chk("ser final count", int'(a_sc), 0);

      // Lock-up: a reseeds, b stays locked until a parallel load
      cyc_ab(0, 0, 0, 0, 1, 0, "lk_load0");
      cyc_ab(0, 1, 0, 0, 0, 0, "lk_run0");
      chk("lk a lockup set", int'(a_lk), 1);
      chk("lk a reseeded", int'(a_st), 1);
      chk("lk b lockup set", int'(b_lk), 1);
      cyc_ab(0, 1, 0, 0, 0, 0, "lk_run1");
      chk("lk a after reseed", int'(a_st), 2);
      chk("lk a lockup clear", int'(a_lk), 0);
      cyc_ab(0, 1, 0, 0, 0, 0, "lk_run2");
      chk("lk b still zero", int'(b_st), 0);
      chk("lk b still locked", int'(b_lk), 1);
      cyc_ab(0, 0, 0, 0, 1, 5, "lk_reload");
      chk("lk b cleared", int'(b_lk), 0);
      chk("lk b reloaded", int'(b_st), 5);

      // Hold, load priority, reset priority
      cyc_ab(1, 0, 0, 0, 0, 0, "pri_rst");
      for (int i = 0; i < 3; i++) cyc_ab(0, 1, 0, 0, 0, 0, "pri_run");
      for (int i = 0; i < 5; i++) begin
         cyc_ab(0, 0, 1, 1, 0, 0, "hold");
         chk("hold state const", int'(a_st), 9);
         chk("hold count const", int'(a_sc), 3);
      end
      cyc_ab(0, 1, 1, 1, 1, 6, "pl_over_serial");
      chk("pl over serial state", int'(a_st), 6);
      cyc_ab(1, 1, 0, 0, 1, 12, "rst_over_pl");
      chk("rst over pl state", int'(a_st), 1);

      // Randomised traffic on the 4-bit pair
      for (int i = 0; i < 400; i++) begin
         r   = ($urandom_range(0, 63) == 0);
         p   = ($urandom_range(0, 9) == 0);
         e   = ($urandom_range(0, 3) != 0);
         l   = ($urandom_range(0, 3) == 0);
         di  = $urandom_range(0, 1) == 1;
         pdv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
         cyc_ab(r, e, l, di, p, pdv, $sformatf("rnd%0d", i));
      end

      // Default 15-bit build: one full maximal period
      cyc_c(1, 0, 0, 0, 0, 0, "c_reset");
      c_rst = 1'b0; c_en = 1'b1;
      npulse = 0; pulse_at = 0; nseed = 0;
      for (int i = 1; i <= 32767; i++) begin
         @(posedge clk);
         #1;
         if (c_pp) begin
            npulse++;
            pulse_at = i;
         end
         if (c_st == 15'd1 && i < 32767) nseed++;
      end
      chk("c period pulses", npulse, 1);
      chk("c pulse step", pulse_at, 32767);
      chk("c early seed hits", nseed, 0);
      chk("c end state", int'(c_st), 1);
      chk("c end count", int'(c_sc), 0);

      cyc_c(1, 0, 0, 0, 0, 0, "c_rereset");
      for (int i = 0; i < 150; i++) begin
         r   = ($urandom_range(0, 63) == 0);
         p   = ($urandom_range(0, 11) == 0);
         e   = ($urandom_range(0, 3) != 0);
         l   = ($urandom_range(0, 4) == 0);
         di  = $urandom_range(0, 1) == 1;
         pdv = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 32767));
         cyc_c(r, e, l, di, p, pdv, $sformatf("crnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
